fifo_sync_prog: RTL and testbench

- Single-clock FIFO, the next generation of the team's shared-clock FIFO.
- Adds full-depth pointer tracking, guarded writes and reads, and runtime-programmable almost-full/almost-empty thresholds.
- Adds sticky overflow/underflow error flags and a registered read-data path with a valid strobe.
- Sits between producer and consumer datapaths in the same clock domain. A compile-time first-word-fall-through (FWFT) option is provided.

---
 rtl/fifo_pkg.sv | 36 +++
 rtl/fifo_sync_ram.sv | 52 +++++
 rtl/fifo_sync_prog.sv | 152 +++++++++++++++
 tb/tb_fifo_sync_prog.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the synchronous programmable FIFO family.
// Status/error bundles carry the widest legal fill so one typedef serves every ADDR_WIDTH.
package fifo_pkg;

    // Widest fill field: ADDR_WIDTH up to 16 gives fill values 0..65536 (17 bits).
    localparam int unsigned FILL_MAX_W = 17;

    // Single definition of depth from address width.
    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    typedef struct packed {
        logic [FILL_MAX_W-1:0] fill;
        logic                  full;
        logic                  empty;
        logic                  almost_full;
        logic                  almost_empty;
    } fifo_status_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    localparam fifo_status_t FIFO_STATUS_RST = '{
        fill:         {FILL_MAX_W{1'b0}},
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

    localparam fifo_err_t FIFO_ERR_RST = '{overflow: 1'b0, underflow: 1'b0};

endpackage

// File: rtl/fifo_sync_ram.sv
// Storage array for fifo_sync_prog: synchronous write port and a read port
// that is either registered (REG_READ=1, read on i_re) or combinational.
module fifo_sync_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter bit REG_READ   = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    // Write port: memory contents are intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    generate
        if (REG_READ) begin : g_reg_read
            logic [DATA_WIDTH-1:0] r_rdata;

            // Registered read: capture the addressed word on an accepted read, hold otherwise.
            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    r_rdata <= {DATA_WIDTH{1'b0}};
                end else if (i_re) begin
                    r_rdata <= r_mem[i_raddr];
                end
            end

            assign o_rdata = r_rdata;
        end else begin : g_comb_read
            logic w_unused_rd;
            assign w_unused_rd = i_re ^ i_rstn;
            assign o_rdata     = r_mem[i_raddr];
        end
    endgenerate

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with full-depth pointers, guarded accesses, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Define FIFO_SYNC_PROG_FWFT_EN for first-word-fall-through read data;
// otherwise read data is registered with a one-cycle o_rvalid strobe.
module fifo_sync_prog
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_wr,
    input  logic                  i_rd,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_rvalid,
    input  logic [ADDR_WIDTH:0]   i_af_level,
    input  logic [ADDR_WIDTH:0]   i_ae_level,
    input  logic                  i_clr_err,
    output logic [ADDR_WIDTH:0]   o_fill,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int unsigned   DEPTH     = fifo_depth(ADDR_WIDTH);
    localparam int            FW        = ADDR_WIDTH + 1;
    localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);
`ifdef FIFO_SYNC_PROG_FWFT_EN
    localparam bit            REG_READ  = 1'b0;
`else
    localparam bit            REG_READ  = 1'b1;
`endif

    logic [FW-1:0]         r_wptr;
    logic [FW-1:0]         r_rptr;
    fifo_status_t          r_status;
    fifo_status_t          w_status_next;
    fifo_err_t             r_err;
    fifo_err_t             w_err_next;
    logic                  w_wa;
    logic                  w_ra;
    logic [FW-1:0]         w_fill_cur;
    logic [FW-1:0]         w_fill_next;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_fill_cur = r_status.fill[FW-1:0];
    assign w_wa       = i_wr & ~r_status.full;
    assign w_ra       = i_rd & ~r_status.empty;

    // Next occupancy and every flag derived from it, using the live thresholds.
    always_comb begin
        w_status_next              = FIFO_STATUS_RST;
        w_fill_next                = w_fill_cur + FW'(w_wa) - FW'(w_ra);
        w_status_next.fill         = FILL_MAX_W'(w_fill_next);
        w_status_next.full         = (w_fill_next == FILL_FULL);
        w_status_next.empty        = (w_fill_next == {FW{1'b0}});
        w_status_next.almost_full  = (w_fill_next >= i_af_level);
        w_status_next.almost_empty = (w_fill_next <= i_ae_level);
    end

    // Sticky error flags: a set event in the same cycle beats the clear.
    always_comb begin
        w_err_next = r_err;
        if (i_wr & r_status.full) begin
            w_err_next.overflow = 1'b1;
        end else if (i_clr_err) begin
            w_err_next.overflow = 1'b0;
        end else begin
            w_err_next.overflow = r_err.overflow;
        end
        if (i_rd & r_status.empty) begin
            w_err_next.underflow = 1'b1;
        end else if (i_clr_err) begin
            w_err_next.underflow = 1'b0;
        end else begin
            w_err_next.underflow = r_err.underflow;
        end
    end

    // Pointers, status and errors advance together so fill == wptr - rptr always holds.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wptr   <= {FW{1'b0}};
            r_rptr   <= {FW{1'b0}};
            r_status <= FIFO_STATUS_RST;
            r_err    <= FIFO_ERR_RST;
        end else begin
            if (w_wa) begin
                r_wptr <= r_wptr + FW'(1);
            end
            if (w_ra) begin
                r_rptr <= r_rptr + FW'(1);
            end
            r_status <= w_status_next;
            r_err    <= w_err_next;
        end
    end

    fifo_sync_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_READ   (REG_READ)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_we    (w_wa),
        .i_waddr (r_wptr[ADDR_WIDTH-1:0]),
        .i_wdata (i_data),
        .i_re    (w_ra),
        .i_raddr (r_rptr[ADDR_WIDTH-1:0]),
        .o_rdata (w_rdata)
    );

`ifdef FIFO_SYNC_PROG_FWFT_EN
    assign o_rvalid = ~r_status.empty;
`else
    logic r_rvalid;

    // Valid strobe for the registered read data: high only in the cycle after an accepted read.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_ra;
        end
    end

    assign o_rvalid = r_rvalid;
`endif

    generate
        if (FILL_MAX_W > FW) begin : g_fill_hi
            logic w_unused_fill_hi;
            assign w_unused_fill_hi = ^r_status.fill[FILL_MAX_W-1:FW];
        end
    endgenerate

    assign o_data         = w_rdata;
    assign o_fill         = w_fill_cur;
    assign o_full         = r_status.full;
    assign o_empty        = r_status.empty;
    assign o_almost_full  = r_status.almost_full;
    assign o_almost_empty = r_status.almost_empty;
    assign o_overflow     = r_err.overflow;
    assign o_underflow    = r_err.underflow;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Self-checking bench for fifo_sync_prog (DATA_WIDTH=8, ADDR_WIDTH=2).
// Reference model: a queue of words plus two sticky flags, updated per cycle.
module tb_fifo_sync_prog;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
`ifdef FIFO_SYNC_PROG_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic          i_clk      = 1'b0;
    logic          i_rstn     = 1'b0;
    logic [DW-1:0] i_data     = 8'h00;
    logic          i_wr       = 1'b0;
    logic          i_rd       = 1'b0;
    logic [AW:0]   i_af_level = 3'd3;
    logic [AW:0]   i_ae_level = 3'd1;
    logic          i_clr_err  = 1'b0;
    logic [DW-1:0] o_data;
    logic          o_rvalid;
    logic [AW:0]   o_fill;
    logic          o_full, o_empty, o_almost_full, o_almost_empty, o_overflow, o_underflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] m_q[$];
    logic          m_ovf    = 1'b0;
    logic          m_udf    = 1'b0;
    logic          m_rvalid = 1'b0;
    logic [DW-1:0] m_data   = 8'h00;

    fifo_sync_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_data(i_data), .i_wr(i_wr), .i_rd(i_rd),
        .o_data(o_data), .o_rvalid(o_rvalid), .i_af_level(i_af_level), .i_ae_level(i_ae_level),
        .i_clr_err(i_clr_err), .o_fill(o_fill), .o_full(o_full), .o_empty(o_empty),
        .o_almost_full(o_almost_full), .o_almost_empty(o_almost_empty),
        .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    always #5 i_clk = ~i_clk;

    // Drive one cycle of requests, advance the model, and return 1 time unit after the edge.
    task automatic drive_cycle(input logic wr, input logic rd, input logic [DW-1:0] d, input logic clr);
        bit was_full, was_empty, wa, ra;
        @(negedge i_clk);
        i_wr = wr; i_rd = rd; i_data = d; i_clr_err = clr;
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        wa = wr && !was_full;
        ra = rd && !was_empty;
        if (wr && was_full) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
        if (rd && was_empty) m_udf = 1'b1; else if (clr) m_udf = 1'b0;
        if (FWFT) begin
            if (ra) void'(m_q.pop_front());
            if (wa) m_q.push_back(d);
            m_rvalid = (m_q.size() != 0);
            if (m_q.size() != 0) m_data = m_q[0];
        end else begin
            m_rvalid = ra;
            if (ra) m_data = m_q.pop_front();
            if (wa) m_q.push_back(d);
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rstn = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        n_checks++; if (o_fill !== 3'd0) begin n_errors++; $display("FAIL rst_fill: got %0d exp 0", o_fill); end
        n_checks++; if (o_empty !== 1'b1 || o_almost_empty !== 1'b1) begin n_errors++; $display("FAIL rst_empty: got %b%b exp 11", o_empty, o_almost_empty); end
        n_checks++; if (o_full !== 1'b0 || o_almost_full !== 1'b0) begin n_errors++; $display("FAIL rst_full: got %b%b exp 00", o_full, o_almost_full); end
        n_checks++; if (o_overflow !== 1'b0 || o_underflow !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b%b exp 00", o_overflow, o_underflow); end
        n_checks++; if (o_rvalid !== 1'b0) begin n_errors++; $display("FAIL rst_rvalid: got %b exp 0", o_rvalid); end
        if (!FWFT) begin
            n_checks++; if (o_data !== 8'h00) begin n_errors++; $display("FAIL rst_data: got %h exp 00", o_data); end
        end
        @(negedge i_clk);
        i_rstn = 1'b1;
    endtask

    task automatic test_fill_sequence();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 1'b0, 8'hA1 + 8'(i), 1'b0);
            n_checks++; if (o_fill !== 3'(i + 1)) begin n_errors++; $display("FAIL seq_fill%0d: got %0d exp %0d", i, o_fill, i + 1); end
            n_checks++; if (o_empty !== 1'b0) begin n_errors++; $display("FAIL seq_empty%0d: got %b exp 0", i, o_empty); end
            n_checks++; if (o_almost_empty !== (i == 0)) begin n_errors++; $display("FAIL seq_ae%0d: got %b exp %b", i, o_almost_empty, (i == 0)); end
            n_checks++; if (o_almost_full !== (i >= 2)) begin n_errors++; $display("FAIL seq_af%0d: got %b exp %b", i, o_almost_full, (i >= 2)); end
            n_checks++; if (o_full !== (i == 3)) begin n_errors++; $display("FAIL seq_full%0d: got %b exp %b", i, o_full, (i == 3)); end
        end
    endtask

    task automatic test_overflow();
        drive_cycle(1'b1, 1'b0, 8'hFF, 1'b0);
        n_checks++; if (o_fill !== 3'd4) begin n_errors++; $display("FAIL ovf_fill: got %0d exp 4", o_fill); end
        n_checks++; if (o_overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_flag: got %b exp 1", o_overflow); end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b1, 8'h00, 1'b0);
            n_checks++; if (o_fill !== 3'(3 - i)) begin n_errors++; $display("FAIL drain_fill%0d: got %0d exp %0d", i, o_fill, 3 - i); end
            if (!FWFT) begin
                n_checks++; if (o_rvalid !== 1'b1 || o_data !== 8'hA1 + 8'(i)) begin n_errors++; $display("FAIL drain_data%0d: got %b/%h exp 1/%h", i, o_rvalid, o_data, 8'hA1 + 8'(i)); end
            end
        end
    endtask

    task automatic test_underflow();
        drive_cycle(1'b0, 1'b1, 8'h00, 1'b0);
        n_checks++; if (o_underflow !== 1'b1) begin n_errors++; $display("FAIL udf_flag: got %b exp 1", o_underflow); end
        n_checks++; if (o_rvalid !== 1'b0 || o_fill !== 3'd0 || o_empty !== 1'b1) begin n_errors++; $display("FAIL udf_state: got %b/%0d/%b exp 0/0/1", o_rvalid, o_fill, o_empty); end
        drive_cycle(1'b0, 1'b1, 8'h00, 1'b1);
        n_checks++; if (o_underflow !== 1'b1) begin n_errors++; $display("FAIL udf_setwins: got %b exp 1", o_underflow); end
        n_checks++; if (o_overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clear: got %b exp 0", o_overflow); end
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        n_checks++; if (o_underflow !== 1'b0) begin n_errors++; $display("FAIL udf_clear: got %b exp 0", o_underflow); end
    endtask

    task automatic test_wrap();
        drive_cycle(1'b1, 1'b0, 8'h11, 1'b0);
        drive_cycle(1'b1, 1'b0, 8'h22, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b1, 1'b1, 8'($urandom), 1'b0);
            n_checks++; if (o_fill !== 3'd2) begin n_errors++; $display("FAIL wrap_fill%0d: got %0d exp 2", i, o_fill); end
            n_checks++; if (o_rvalid !== 1'b1 || o_data !== m_data) begin n_errors++; $display("FAIL wrap_data%0d: got %b/%h exp 1/%h", i, o_rvalid, o_data, m_data); end
        end
    endtask

    task automatic test_threshold();
        i_af_level = 3'd2; i_ae_level = 3'd1;
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        n_checks++; if (o_almost_full !== 1'b1 || o_almost_empty !== 1'b0) begin n_errors++; $display("FAIL thr_af2: got %b%b exp 10", o_almost_full, o_almost_empty); end
        i_af_level = 3'd3; i_ae_level = 3'd2;
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        n_checks++; if (o_almost_full !== 1'b0 || o_almost_empty !== 1'b1) begin n_errors++; $display("FAIL thr_ae2: got %b%b exp 01", o_almost_full, o_almost_empty); end
        i_af_level = 3'd3; i_ae_level = 3'd1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 19) == 0) begin
                i_af_level = 3'($urandom_range(0, 5));
                i_ae_level = 3'($urandom_range(0, 5));
            end
            drive_cycle(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50), 8'($urandom), ($urandom_range(0, 9) == 0));
            n_checks++;
            if (o_fill !== 3'(m_q.size()) || o_full !== (m_q.size() == DEPTH) || o_empty !== (m_q.size() == 0)
                || o_almost_full !== (m_q.size() >= int'(i_af_level)) || o_almost_empty !== (m_q.size() <= int'(i_ae_level))) begin
                n_errors++;
                $display("FAIL rnd_status c=%0d: got fill=%0d f=%b e=%b af=%b ae=%b exp fill=%0d", c, o_fill, o_full, o_empty, o_almost_full, o_almost_empty, m_q.size());
            end
            n_checks++; if (o_overflow !== m_ovf || o_underflow !== m_udf) begin n_errors++; $display("FAIL rnd_err c=%0d: got %b%b exp %b%b", c, o_overflow, o_underflow, m_ovf, m_udf); end
            n_checks++; if (o_rvalid !== m_rvalid) begin n_errors++; $display("FAIL rnd_rvalid c=%0d: got %b exp %b", c, o_rvalid, m_rvalid); end
            if (!FWFT || m_rvalid) begin
                n_checks++; if (o_data !== m_data) begin n_errors++; $display("FAIL rnd_data c=%0d: got %h exp %h", c, o_data, m_data); end
            end
        end
        i_af_level = 3'd3; i_ae_level = 3'd1;
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 8 && m_q.size() != 0; k++) drive_cycle(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 8'h70 + 8'(i), 1'b0);
        n_checks++; if (o_fill !== 3'd3) begin n_errors++; $display("FAIL mid_prefill: got %0d exp 3", o_fill); end
        #2;
        i_rstn = 1'b0; i_wr = 1'b0; i_rd = 1'b0; i_clr_err = 1'b0;
        #1;
        n_checks++; if (o_fill !== 3'd0 || o_empty !== 1'b1 || o_almost_empty !== 1'b1) begin n_errors++; $display("FAIL mid_rst_fill: got %0d/%b/%b exp 0/1/1", o_fill, o_empty, o_almost_empty); end
        n_checks++; if (o_full !== 1'b0 || o_almost_full !== 1'b0 || o_overflow !== 1'b0 || o_underflow !== 1'b0 || o_rvalid !== 1'b0) begin n_errors++; $display("FAIL mid_rst_flags: got %b%b%b%b%b exp 00000", o_full, o_almost_full, o_overflow, o_underflow, o_rvalid); end
        m_q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_rvalid = 1'b0; m_data = 8'h00;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rstn = 1'b1;
        drive_cycle(1'b1, 1'b0, 8'h3C, 1'b0);
        n_checks++; if (o_fill !== 3'd1) begin n_errors++; $display("FAIL mid_wr_fill: got %0d exp 1", o_fill); end
        drive_cycle(1'b0, 1'b1, 8'h00, 1'b0);
        n_checks++; if (o_fill !== 3'd0) begin n_errors++; $display("FAIL mid_rd_fill: got %0d exp 0", o_fill); end
        if (!FWFT) begin
            n_checks++; if (o_rvalid !== 1'b1 || o_data !== 8'h3C) begin n_errors++; $display("FAIL mid_rd_data: got %b/%h exp 1/3c", o_rvalid, o_data); end
        end
    endtask

`ifdef FIFO_SYNC_PROG_FWFT_EN
    task automatic test_fwft();
        drive_cycle(1'b1, 1'b0, 8'h5C, 1'b0);
        n_checks++; if (o_rvalid !== 1'b1 || o_data !== 8'h5C) begin n_errors++; $display("FAIL fwft_show: got %b/%h exp 1/5c", o_rvalid, o_data); end
        drive_cycle(1'b0, 1'b1, 8'h00, 1'b0);
        n_checks++; if (o_empty !== 1'b1 || o_rvalid !== 1'b0) begin n_errors++; $display("FAIL fwft_pop: got %b/%b exp 1/0", o_empty, o_rvalid); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_sequence();
        test_overflow();
        test_underflow();
        test_wrap();
        test_threshold();
        test_random();
        test_reset_mid();
`ifdef FIFO_SYNC_PROG_FWFT_EN
        test_fwft();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
